// File: rtl/l2_write_queue.sv
// L2 write-side sequencer: in-order queue, paced write-port issue, read alias flag.
// Define L2_WRQ_COALESCE_EN to merge repeat writes into the newest queued entry.
module l2_write_queue #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [1:0]  ReqCmd,
    input  logic [25:0] ReqA,
    input  logic [31:0] ReqD,
    input  logic [3:0]  ReqM,
    input  logic [25:0] RDA,
    output logic        PendHit,
    output logic [25:0] WRA,
    output logic [31:0] WRD,
    output logic [3:0]  WRM,
    output logic        TS,
    output logic        WR,
    output logic        CLR,
    output logic        ALL,
    output logic        Busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [1:0] CMD_WR     = 2'b00;
    localparam logic [1:0] CMD_FILL   = 2'b01;
    localparam logic [1:0] CMD_INVALL = 2'b11;

    localparam logic [2:0] GAP_LD = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    logic [1:0]    q_cmd [DEPTH];
    logic [25:0]   q_a   [DEPTH];
    logic [31:0]   q_d   [DEPTH];
    logic [3:0]    q_m   [DEPTH];

    logic [AW:0]   wp;
    logic [AW:0]   rp;
    logic [AW:0]   cnt;
    logic [AW-1:0] wi;
    logic [AW-1:0] ri;
    logic [AW-1:0] off;
    logic [1:0]    state;
    logic [2:0]    gcnt;
    logic [1:0]    cur_cmd;
    logic          full;
    logic          empty;
    logic          pop;
    logic          acc;
    logic          push;
    logic          merge;

    assign wi    = wp[AW-1:0];
    assign ri    = rp[AW-1:0];
    assign cnt   = wp - rp;
    assign empty = (wp == rp);
    assign full  = cnt[AW];
    assign pop   = (state == S_IDLE) && !empty;
    assign acc   = ReqValid && ReqReady;
    assign push  = acc && !merge;
    assign Busy  = !empty || (state != S_IDLE);

`ifdef L2_WRQ_COALESCE_EN
    logic [AW-1:0] ni;
    logic          elig;
    logic [31:0]   mdat;

    assign ni = wi - AW'(1);

    // the head being popped this edge can no longer absorb data
    assign elig = (ReqCmd == CMD_WR) && !empty &&
                  (q_cmd[ni] == CMD_WR) && (q_a[ni] == ReqA) &&
                  !(pop && (cnt == (AW+1)'(1)));

    assign merge    = ReqValid && elig;
    assign ReqReady = !full || elig;

    always_comb begin
        mdat = q_d[ni];
        for (int b = 0; b < 4; b++) begin
            if (ReqM[b]) mdat[8*b +: 8] = ReqD[8*b +: 8];
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_cmd[wi] <= ReqCmd;
            q_a[wi]   <= ReqA;
            q_d[wi]   <= ReqD;
            q_m[wi]   <= (ReqCmd == CMD_FILL) ? 4'hF : ReqM;
        end else if (merge) begin
            q_d[ni] <= mdat;
            q_m[ni] <= q_m[ni] | ReqM;
        end
    end
`else
    assign merge    = 1'b0;
    assign ReqReady = !full;

    always_ff @(posedge CLK) begin
        if (push) begin
            q_cmd[wi] <= ReqCmd;
            q_a[wi]   <= ReqA;
            q_d[wi]   <= ReqD;
            q_m[wi]   <= (ReqCmd == CMD_FILL) ? 4'hF : ReqM;
        end
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wp      <= '0;
            rp      <= '0;
            state   <= S_IDLE;
            gcnt    <= 3'd0;
            cur_cmd <= 2'b00;
            WRA     <= 26'd0;
            WRD     <= 32'd0;
            WRM     <= 4'd0;
            TS      <= 1'b0;
            WR      <= 1'b0;
            CLR     <= 1'b0;
            ALL     <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            TS  <= 1'b0;
            WR  <= 1'b0;
            CLR <= 1'b0;
            ALL <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        rp      <= rp + 1'b1;
                        cur_cmd <= q_cmd[ri];
                        WRA     <= q_a[ri];
                        WRD     <= q_d[ri];
                        WRM     <= q_m[ri];
                        WR      <= !q_cmd[ri][1];
                        TS      <= (q_cmd[ri] == CMD_FILL);
                        CLR     <= q_cmd[ri][1];
                        ALL     <= (q_cmd[ri] == CMD_INVALL);
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (GAP > 0) begin
                        state <= S_GAP;
                        gcnt  <= GAP_LD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gcnt == 3'd0) state <= S_IDLE;
                    else gcnt <= gcnt - 3'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PendHit = 1'b0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - ri;
            if ({1'b0, off} < cnt) begin
                if (q_cmd[i] == CMD_INVALL) PendHit = 1'b1;
                if (!q_cmd[i][1] && (q_a[i] == RDA)) PendHit = 1'b1;
            end
        end
        if (state == S_ISSUE) begin
            if (cur_cmd == CMD_INVALL) PendHit = 1'b1;
            if (!cur_cmd[1] && (WRA == RDA)) PendHit = 1'b1;
        end
    end

endmodule

// File: tb/tb_l2_write_queue.sv
// Bench for l2_write_queue: directed scenarios plus random traffic
// against a queue/timing reference model.
module tb_l2_write_queue;

    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    localparam int P     = 2 + GAP;

    typedef struct {
        int          cyc;
        logic        wr;
        logic        ts;
        logic        clr;
        logic        all;
        logic [25:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } ev_t;

    typedef struct {
        logic [1:0]  cmd;
        logic [25:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } rq_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic [1:0]  ReqCmd = 2'b00;
    logic [25:0] ReqA = '0;
    logic [31:0] ReqD = '0;
    logic [3:0]  ReqM = '0;
    logic [25:0] RDA = '0;
    logic        PendHit;
    logic [25:0] WRA;
    logic [31:0] WRD;
    logic [3:0]  WRM;
    logic        TS;
    logic        WR;
    logic        CLR;
    logic        ALL;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    ev_t evq[$];

    l2_write_queue #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .CLK(CLK), .nRST(nRST),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqCmd(ReqCmd), .ReqA(ReqA), .ReqD(ReqD), .ReqM(ReqM),
        .RDA(RDA), .PendHit(PendHit),
        .WRA(WRA), .WRD(WRD), .WRM(WRM),
        .TS(TS), .WR(WR), .CLR(CLR), .ALL(ALL), .Busy(Busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // strobe log, sampled mid-cycle
    always @(negedge CLK) begin
        if (WR === 1'b1 || CLR === 1'b1) begin
            ev_t e;
            e.cyc = cyc; e.wr = WR; e.ts = TS; e.clr = CLR; e.all = ALL;
            e.a = WRA; e.d = WRD; e.m = WRM;
            evq.push_back(e);
        end
    end

    task automatic put(input logic [1:0] c, input logic [25:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        @(negedge CLK); #1;
        ReqValid = 1'b1; ReqCmd = c; ReqA = a; ReqD = d; ReqM = m;
        @(posedge CLK); #1;
    endtask

    task automatic quiet();
        @(negedge CLK); #1;
        ReqValid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        ReqValid = 1'b0;
        while (Busy !== 1'b0 && k < 200) begin
            @(posedge CLK); #1;
            k++;
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout busy=%b want 0", Busy);
        end
    endtask

    task automatic test_reset();
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({WRA, WRD, WRM, TS, WR, CLR, ALL} !== 66'd0) begin
            errors++;
            $display("FAIL rst_out got %h want 0",
                     {WRA, WRD, WRM, TS, WR, CLR, ALL});
        end
        checks++;
        if ({ReqReady, Busy, PendHit} !== 3'b100) begin
            errors++;
            $display("FAIL rst_ctl got rdy/busy/ph=%b want 100",
                     {ReqReady, Busy, PendHit});
        end
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (Busy !== 1'b0 || WR !== 1'b0) begin
            errors++;
            $display("FAIL rst_release busy=%b wr=%b want 0 0", Busy, WR);
        end
    endtask

    task automatic test_single_write();
        int n;
        evq.delete();
        put(2'b00, 26'h0000123, 32'hDEADBEEF, 4'b0011);
        n = cyc;
        checks++;
        if (WR !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL sw_accept wr=%b busy=%b want 0 1", WR, Busy);
        end
        quiet();
        @(posedge CLK); #1;
        checks++;
        if ({WR, TS, CLR, ALL} !== 4'b1000) begin
            errors++;
            $display("FAIL sw_strobe got %b want 1000", {WR, TS, CLR, ALL});
        end
        checks++;
        if (WRA !== 26'h123 || WRD !== 32'hDEADBEEF || WRM !== 4'b0011) begin
            errors++;
            $display("FAIL sw_data got %h %h %h want 123 deadbeef 3",
                     WRA, WRD, WRM);
        end
        @(posedge CLK); #1;
        checks++;
        if (WR !== 1'b0 || WRA !== 26'h123) begin
            errors++;
            $display("FAIL sw_drop wr=%b wra=%h want 0 123", WR, WRA);
        end
        for (int k = 0; k < GAP; k++) begin
            checks++;
            if (Busy !== 1'b1) begin
                errors++;
                $display("FAIL sw_gap%0d busy=%b want 1", k, Busy);
            end
            @(posedge CLK); #1;
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL sw_idle busy=%b want 0", Busy);
        end
        checks++;
        if (evq.size() != 1 || evq[0].cyc != n + 1) begin
            errors++;
            $display("FAIL sw_count got %0d strobes want 1 at %0d",
                     evq.size(), n + 1);
        end
    endtask

    task automatic test_order();
        int n;
        wait_idle();
        evq.delete();
        put(2'b01, 26'h10, 32'h11111111, 4'h0);
        n = cyc;
        put(2'b00, 26'h11, 32'h22222222, 4'b0101);
        put(2'b11, 26'h3FFFFFF, 32'h0, 4'h0);
        quiet();
        for (int k = 0; k < 60 && evq.size() < 3; k++) @(negedge CLK);
        #1;
        checks++;
        if (evq.size() != 3) begin
            errors++;
            $display("FAIL ord_count got %0d want 3", evq.size());
        end else begin
            checks++;
            if (evq[0].cyc != n + 1 || evq[1].cyc != n + 1 + P ||
                evq[2].cyc != n + 1 + 2 * P) begin
                errors++;
                $display("FAIL ord_time got %0d %0d %0d want %0d %0d %0d",
                         evq[0].cyc, evq[1].cyc, evq[2].cyc,
                         n + 1, n + 1 + P, n + 1 + 2 * P);
            end
            checks++;
            if ({evq[0].wr, evq[0].ts, evq[0].clr} !== 3'b110 ||
                evq[0].m !== 4'hF || evq[0].a !== 26'h10) begin
                errors++;
                $display("FAIL ord_fill got s=%b%b%b m=%h a=%h want 110 f 10",
                         evq[0].wr, evq[0].ts, evq[0].clr, evq[0].m, evq[0].a);
            end
            checks++;
            if ({evq[1].wr, evq[1].ts} !== 2'b10 || evq[1].a !== 26'h11 ||
                evq[1].m !== 4'b0101 || evq[1].d !== 32'h22222222) begin
                errors++;
                $display("FAIL ord_write got ts=%b a=%h m=%h d=%h", evq[1].ts,
                         evq[1].a, evq[1].m, evq[1].d);
            end
            checks++;
            if ({evq[2].wr, evq[2].clr, evq[2].all} !== 3'b011) begin
                errors++;
                $display("FAIL ord_invall got wr/clr/all=%b%b%b want 011",
                         evq[2].wr, evq[2].clr, evq[2].all);
            end
        end
    endtask

    task automatic test_full();
        int acc = 0;
        int occ;
        int k = 0;
        bit saw = 0;
        bit rdy;
        logic [31:0] dq [DEPTH + 4];
        wait_idle();
        evq.delete();
        while (acc < DEPTH + 4 && k < 200) begin
            @(negedge CLK); #1;
            occ = acc - evq.size();
            ReqValid = 1'b1;
            ReqCmd = 2'b00;
            ReqA = 26'h100 + 26'(acc);
            ReqD = $urandom;
            ReqM = 4'hF;
            dq[acc] = ReqD;
            #1;
            checks++;
            if (ReqReady !== 1'(occ < DEPTH)) begin
                errors++;
                $display("FAIL full_ready occ=%0d got %b want %b",
                         occ, ReqReady, occ < DEPTH);
            end
            rdy = ReqReady;
            if (!rdy) saw = 1;
            @(posedge CLK);
            if (rdy) acc++;
            k++;
        end
        quiet();
        for (int j = 0; j < 100 && evq.size() < DEPTH + 4; j++)
            @(negedge CLK);
        #1;
        checks++;
        if (acc != DEPTH + 4 || !saw) begin
            errors++;
            $display("FAIL full_seen acc=%0d saw=%0d want %0d 1",
                     acc, saw, DEPTH + 4);
        end
        checks++;
        if (evq.size() != DEPTH + 4) begin
            errors++;
            $display("FAIL full_count got %0d want %0d",
                     evq.size(), DEPTH + 4);
        end else begin
            for (int i = 0; i < DEPTH + 4; i++) begin
                checks++;
                if (evq[i].a !== 26'h100 + 26'(i) || evq[i].d !== dq[i]) begin
                    errors++;
                    $display("FAIL full_ent%0d got %h %h want %h %h", i,
                             evq[i].a, evq[i].d, 26'h100 + 26'(i), dq[i]);
                end
            end
        end
    endtask

    task automatic test_pendhit();
        wait_idle();
        RDA = 26'h2A1;
        put(2'b00, 26'h2A0, 32'h5, 4'h1);
        RDA = 26'h2A0;
        #1;
        checks++;
        if (PendHit !== 1'b1) begin
            errors++;
            $display("FAIL ph_hit got %b want 1", PendHit);
        end
        RDA = 26'h2A1;
        #1;
        checks++;
        if (PendHit !== 1'b0) begin
            errors++;
            $display("FAIL ph_miss got %b want 0", PendHit);
        end
        quiet();
        RDA = 26'h2A0;
        @(posedge CLK); #1;
        checks++;
        if (WR !== 1'b1 || PendHit !== 1'b1) begin
            errors++;
            $display("FAIL ph_issue wr=%b ph=%b want 1 1", WR, PendHit);
        end
        @(posedge CLK); #1;
        checks++;
        if (PendHit !== 1'b0) begin
            errors++;
            $display("FAIL ph_clear got %b want 0", PendHit);
        end
        wait_idle();
        put(2'b11, 26'h0, 32'h0, 4'h0);
        RDA = 26'h155;
        #1;
        checks++;
        if (PendHit !== 1'b1) begin
            errors++;
            $display("FAIL ph_invall got %b want 1", PendHit);
        end
        quiet();
        wait_idle();
        checks++;
        if (PendHit !== 1'b0) begin
            errors++;
            $display("FAIL ph_idle got %b want 0", PendHit);
        end
    endtask

    task automatic test_reset_mid_gap();
        wait_idle();
        evq.delete();
        RDA = 26'h31;
        put(2'b00, 26'h31, 32'hA5A5A5A5, 4'hF);
        put(2'b00, 26'h32, 32'h5A5A5A5A, 4'hF);
        put(2'b01, 26'h33, 32'h01020304, 4'h0);
        checks++;
        if (WR !== 1'b0 || Busy !== 1'b1 || evq.size() != 1 ||
            WRA !== 26'h31) begin
            errors++;
            $display("FAIL rg_pre wr=%b busy=%b n=%0d wra=%h want 0 1 1 31",
                     WR, Busy, evq.size(), WRA);
        end
        nRST = 1'b0;
        ReqValid = 1'b0;
        #1;
        checks++;
        if ({WRA, WRD, WRM, TS, WR, CLR, ALL} !== 66'd0) begin
            errors++;
            $display("FAIL rg_out got %h want 0",
                     {WRA, WRD, WRM, TS, WR, CLR, ALL});
        end
        checks++;
        if ({ReqReady, Busy, PendHit} !== 3'b100) begin
            errors++;
            $display("FAIL rg_ctl got %b want 100", {ReqReady, Busy, PendHit});
        end
        evq.delete();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        checks++;
        if (evq.size() != 0 || Busy !== 1'b0 || WRA !== 26'h0) begin
            errors++;
            $display("FAIL rg_after n=%0d busy=%b wra=%h want 0 0 0",
                     evq.size(), Busy, WRA);
        end
    endtask

    task automatic test_coalesce();
        wait_idle();
        evq.delete();
        put(2'b00, 26'h50, 32'h12345678, 4'hF);
        put(2'b00, 26'h40, 32'h000000AA, 4'b0001);
        put(2'b00, 26'h40, 32'hBB000000, 4'b1000);
        quiet();
        wait_idle();
        repeat (2) @(posedge CLK);
        #1;
`ifdef L2_WRQ_COALESCE_EN
        checks++;
        if (evq.size() != 2) begin
            errors++;
            $display("FAIL co_count got %0d want 2", evq.size());
        end else begin
            checks++;
            if (evq[1].a !== 26'h40 || evq[1].m !== 4'b1001 ||
                evq[1].d[31:24] !== 8'hBB || evq[1].d[7:0] !== 8'hAA) begin
                errors++;
                $display("FAIL co_merge got a=%h m=%b d=%h want 40 1001 bb....aa",
                         evq[1].a, evq[1].m, evq[1].d);
            end
        end
`else
        checks++;
        if (evq.size() != 3) begin
            errors++;
            $display("FAIL co_count got %0d want 3", evq.size());
        end else begin
            checks++;
            if (evq[1].m !== 4'b0001 || evq[1].d !== 32'h000000AA ||
                evq[2].m !== 4'b1000 || evq[2].d !== 32'hBB000000) begin
                errors++;
                $display("FAIL co_split got %b %h %b %h want 0001 aa 1000 bb000000",
                         evq[1].m, evq[1].d, evq[2].m, evq[2].d);
            end
        end
`endif
    endtask

    task automatic test_random();
        rq_t mq[$];
        ev_t xq[$];
        rq_t iss;
        rq_t r;
        ev_t e;
        int next_ok = 0;
        int iss_cyc = -100;
        int c;
        int it = 0;
        bit pop;
        bit elig;
        bit v;
        bit eph;
        bit erdy;
        int sel;
        iss = '{cmd: 2'b00, a: '0, d: '0, m: '0};
        wait_idle();
        evq.delete();
        while ((it < 400 || mq.size() > 0 || cyc < next_ok) && it < 800) begin
            @(negedge CLK); #1;
            c = cyc;
            pop = (mq.size() > 0) && (c + 1 >= next_ok);
            v = (it < 400) && ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 15);
            r.cmd = (sel < 9) ? 2'b00 : (sel < 13) ? 2'b01 :
                    (sel < 15) ? 2'b10 : 2'b11;
            r.a = 26'h40 + 26'($urandom_range(0, 3));
            r.d = $urandom;
            r.m = 4'($urandom_range(0, 15));
            RDA = ($urandom_range(0, 1) == 1) ?
                  26'h40 + 26'($urandom_range(0, 3)) : 26'h3FF;
            ReqValid = v; ReqCmd = r.cmd; ReqA = r.a; ReqD = r.d; ReqM = r.m;
            elig = 0;
`ifdef L2_WRQ_COALESCE_EN
            if (r.cmd == 2'b00 && mq.size() > 0 &&
                mq[mq.size() - 1].cmd == 2'b00 &&
                mq[mq.size() - 1].a == r.a &&
                !(pop && mq.size() == 1)) elig = 1;
`endif
            erdy = (mq.size() < DEPTH) || elig;
            eph = 0;
            foreach (mq[i]) begin
                if (mq[i].cmd == 2'b11) eph = 1;
                if (mq[i].cmd < 2 && mq[i].a == RDA) eph = 1;
            end
            if (iss_cyc == c) begin
                if (iss.cmd == 2'b11) eph = 1;
                if (iss.cmd < 2 && iss.a == RDA) eph = 1;
            end
            #1;
            checks++;
            if (ReqReady !== erdy) begin
                errors++;
                $display("FAIL rnd_ready c=%0d got %b want %b", c, ReqReady, erdy);
            end
            checks++;
            if (PendHit !== eph) begin
                errors++;
                $display("FAIL rnd_pend c=%0d got %b want %b", c, PendHit, eph);
            end
            if (pop) begin
                iss = mq.pop_front();
                iss_cyc = c + 1;
                next_ok = c + 1 + P;
                e.cyc = c + 1;
                e.wr = (iss.cmd < 2);
                e.ts = (iss.cmd == 2'b01);
                e.clr = (iss.cmd >= 2);
                e.all = (iss.cmd == 2'b11);
                e.a = iss.a; e.d = iss.d; e.m = iss.m;
                xq.push_back(e);
            end
            if (v && erdy) begin
                if (elig) begin
                    rq_t t;
                    t = mq[mq.size() - 1];
                    for (int b = 0; b < 4; b++)
                        if (r.m[b]) t.d[8*b +: 8] = r.d[8*b +: 8];
                    t.m = t.m | r.m;
                    mq[mq.size() - 1] = t;
                end else begin
                    if (r.cmd == 2'b01) r.m = 4'hF;
                    mq.push_back(r);
                end
            end
            it++;
        end
        ReqValid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (evq.size() != xq.size()) begin
            errors++;
            $display("FAIL rnd_count got %0d want %0d", evq.size(), xq.size());
        end
        for (int i = 0; i < xq.size() && i < evq.size(); i++) begin
            checks++;
            if (evq[i].cyc != xq[i].cyc || evq[i].wr !== xq[i].wr ||
                evq[i].ts !== xq[i].ts || evq[i].clr !== xq[i].clr ||
                evq[i].all !== xq[i].all || evq[i].a !== xq[i].a ||
                (xq[i].wr && (evq[i].d !== xq[i].d || evq[i].m !== xq[i].m))) begin
                errors++;
                $display("FAIL rnd_ev%0d got c=%0d s=%b%b%b%b a=%h d=%h m=%h want c=%0d s=%b%b%b%b a=%h d=%h m=%h",
                         i, evq[i].cyc, evq[i].wr, evq[i].ts, evq[i].clr,
                         evq[i].all, evq[i].a, evq[i].d, evq[i].m,
                         xq[i].cyc, xq[i].wr, xq[i].ts, xq[i].clr,
                         xq[i].all, xq[i].a, xq[i].d, xq[i].m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_order();
        test_full();
        test_pendhit();
        test_reset_mid_gap();
        test_coalesce();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
